wb_daq_sram_arbiter: RTL and testbench



---
 rtl/wb_daq_sram_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_wb_daq_sram_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_daq_sram_arbiter.sv
// Round-robin arbiter that shares one SRAM write port between several DAQ
// channels. Each served channel's word lands at {channel, write pointer};
// every channel owns a circular region of 2**ow words.
module wb_daq_sram_arbiter #(
   parameter int dw           = 32,
   parameter int num_channels = 4,
   parameter int cw           = 2,
   parameter int ow           = 8,
   parameter int timeout      = 255
) (
   input  logic                       wb_clk,
   input  logic                       wb_rst,
   input  logic                       enable,
   input  logic [num_channels-1:0]    start_sram,
   input  logic [num_channels*dw-1:0] data_in,
   output logic [num_channels-1:0]    grant,
   output logic [num_channels-1:0]    data_done,
   output logic                       sram_we,
   output logic [cw+ow-1:0]           sram_addr,
   output logic [dw-1:0]              sram_data,
   input  logic                       sram_ack,
   input  logic                       status_clear,
   output logic [num_channels-1:0]    channel_wrapped,
   output logic                       bus_error,
   output logic                       busy
);

   typedef enum logic [1:0] {IDLE, GRANT, WRITE, DONE} state_t;

   // Last WRITE cycle index before the write is abandoned.
   localparam logic [7:0] TLAST = 8'(timeout - 1);

   state_t                  state_q, state_d;
   logic [num_channels-1:0] grant_q, grant_d;
   logic [num_channels-1:0] data_done_q, data_done_d;
   logic                    sram_we_q, sram_we_d;
   logic [cw+ow-1:0]        sram_addr_q, sram_addr_d;
   logic [dw-1:0]           sram_data_q, sram_data_d;
   logic [cw-1:0]           sel_q, sel_d;
   logic [cw-1:0]           prio_q, prio_d;
   logic [7:0]              tcnt_q, tcnt_d;
   logic                    aborted_q, aborted_d;
   logic                    bus_error_q, bus_error_d;
   logic                    busy_q, busy_d;

   logic [cw-1:0]           idx;
   logic [cw-1:0]           pick;
   logic                    pick_valid;
   logic [num_channels-1:0] pick_onehot;
   logic [dw-1:0]           sel_data;
   logic [ow-1:0]           sel_wptr;
   logic [ow-1:0]           wptr_bus [num_channels];
   logic                    ptr_advance;
   logic                    timeout_hit;

   // Round-robin search: first requester at or above the priority pointer, wrapping.
   always_comb begin
      pick        = '0;
      pick_valid  = 1'b0;
      idx         = '0;
      pick_onehot = '0;
      for (int k = 0; k < num_channels; k++) begin
         idx = cw'((int'(prio_q) + k) % num_channels);
         if (!pick_valid && start_sram[idx]) begin
            pick_valid = 1'b1;
            pick       = idx;
         end
      end
      for (int k = 0; k < num_channels; k++) begin
         pick_onehot[k] = (pick == cw'(k));
      end
   end

   // Steer the selected channel's word and write pointer toward the capture registers.
   always_comb begin
      sel_data = '0;
      sel_wptr = '0;
      for (int k = 0; k < num_channels; k++) begin
         if (sel_q == cw'(k)) begin
            sel_data = data_in[k*dw +: dw];
            sel_wptr = wptr_bus[k];
         end
      end
   end

   // Next-state and registered-output logic of the transaction FSM.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      data_done_d = '0;
      sram_we_d   = sram_we_q;
      sram_addr_d = sram_addr_q;
      sram_data_d = sram_data_q;
      sel_d       = sel_q;
      prio_d      = prio_q;
      tcnt_d      = tcnt_q;
      aborted_d   = aborted_q;
      timeout_hit = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable && pick_valid) begin
               sel_d   = pick;
               grant_d = pick_onehot;
               state_d = GRANT;
            end
         end
         GRANT: begin
            sram_data_d = sel_data;
            sram_addr_d = {sel_q, sel_wptr};
            sram_we_d   = 1'b1;
            tcnt_d      = '0;
            aborted_d   = 1'b0;
            state_d     = WRITE;
         end
         WRITE: begin
            if (sram_ack) begin
               sram_we_d   = 1'b0;
               data_done_d = grant_q;
               state_d     = DONE;
            end else if (tcnt_q == TLAST) begin
               sram_we_d   = 1'b0;
               data_done_d = grant_q;
               aborted_d   = 1'b1;
               timeout_hit = 1'b1;
               state_d     = DONE;
            end else begin
               tcnt_d = tcnt_q + 8'd1;
            end
         end
         DONE: begin
            grant_d = '0;
            prio_d  = (sel_q == cw'(num_channels - 1)) ? '0 : sel_q + cw'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Sticky bus-error flag; a timeout in the same cycle beats a clear.
   always_comb begin
      bus_error_d = bus_error_q;
      if (status_clear) bus_error_d = 1'b0;
      if (timeout_hit)  bus_error_d = 1'b1;
   end

   assign ptr_advance = (state_q == DONE) && !aborted_q;

   // Per-channel circular write pointer and sticky wrap flag.
   for (genvar gi = 0; gi < num_channels; gi++) begin : g_chan
      logic [ow-1:0] wptr_q, wptr_d;
      logic          wrapped_q, wrapped_d;
      logic          hit;

      assign hit = ptr_advance && (sel_q == cw'(gi));

      // Advance after a successful write; a wrap event beats a same-cycle clear.
      always_comb begin
         wptr_d    = wptr_q;
         wrapped_d = wrapped_q;
         if (status_clear) wrapped_d = 1'b0;
         if (hit) begin
            wptr_d = wptr_q + ow'(1);
            if (&wptr_q) wrapped_d = 1'b1;
         end
      end

      // Pointer and wrap flag registers.
      always_ff @(posedge wb_clk) begin
         if (wb_rst) begin
            wptr_q    <= '0;
            wrapped_q <= 1'b0;
         end else begin
            wptr_q    <= wptr_d;
            wrapped_q <= wrapped_d;
         end
      end

      assign wptr_bus[gi]        = wptr_q;
      assign channel_wrapped[gi] = wrapped_q;
   end

   // FSM state and output registers; reset abandons any in-flight write.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         data_done_q <= '0;
         sram_we_q   <= 1'b0;
         sram_addr_q <= '0;
         sram_data_q <= '0;
         sel_q       <= '0;
         prio_q      <= '0;
         tcnt_q      <= '0;
         aborted_q   <= 1'b0;
         bus_error_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         data_done_q <= data_done_d;
         sram_we_q   <= sram_we_d;
         sram_addr_q <= sram_addr_d;
         sram_data_q <= sram_data_d;
         sel_q       <= sel_d;
         prio_q      <= prio_d;
         tcnt_q      <= tcnt_d;
         aborted_q   <= aborted_d;
         bus_error_q <= bus_error_d;
         busy_q      <= busy_d;
      end
   end

   assign grant     = grant_q;
   assign data_done = data_done_q;
   assign sram_we   = sram_we_q;
   assign sram_addr = sram_addr_q;
   assign sram_data = sram_data_q;
   assign bus_error = bus_error_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_wb_daq_sram_arbiter.sv
// Bench for wb_daq_sram_arbiter: a transaction-timeline model predicts every
// output each cycle; directed scenarios add hand-computed literal checks.
module tb_wb_daq_sram_arbiter;

   localparam int DW = 32;
   localparam int N  = 4;
   localparam int CW = 2;
   localparam int OW = 8;
   localparam int TO = 255;

   logic            clk = 1'b0;
   logic            rst;
   logic            enable;
   logic [N-1:0]    start_sram;
   logic [N*DW-1:0] data_in;
   logic [N-1:0]    grant;
   logic [N-1:0]    data_done;
   logic            sram_we;
   logic [CW+OW-1:0] sram_addr;
   logic [DW-1:0]   sram_data;
   logic            sram_ack = 1'b0;
   logic            status_clear;
   logic [N-1:0]    channel_wrapped;
   logic            bus_error;
   logic            busy;

   wb_daq_sram_arbiter #(
      .dw(DW), .num_channels(N), .cw(CW), .ow(OW), .timeout(TO)
   ) dut (
      .wb_clk(clk),
      .wb_rst(rst),
      .enable(enable),
      .start_sram(start_sram),
      .data_in(data_in),
      .grant(grant),
      .data_done(data_done),
      .sram_we(sram_we),
      .sram_addr(sram_addr),
      .sram_data(sram_data),
      .sram_ack(sram_ack),
      .status_clear(status_clear),
      .channel_wrapped(channel_wrapped),
      .bus_error(bus_error),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int edge_n   = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
   endfunction

   // ---------------- transaction-timeline model ----------------
   // A transaction whose request is seen at edge E with W write cycles shows:
   // grant for E..E+W+1, sram_we for E+1..E+W, data_done after E+W+1,
   // and frees the port at edge E+W+2.
   int          ack_wait = 0;   // WRITE cycles before ack; -1 withholds ack
   bit          model_on = 0;
   bit          m_active = 0;
   int          m_E, m_W, m_sel;
   bit          m_abort;
   int          m_wptr [N];
   int          m_prio;
   bit [N-1:0]  m_wrapped;
   bit          m_buserr;
   logic [CW+OW-1:0] m_addr;
   logic [DW-1:0]    m_data;
   int          m_done_cnt = 0;

   int          glog_ch [$];
   int          glog_edge [$];
   logic [N-1:0] prev_grant = '0;
   int          we_cnt = 0;

   task automatic model_edge();
      int offs;
      if (rst) begin
         model_on  = 1;
         m_active  = 0;
         for (int k = 0; k < N; k++) m_wptr[k] = 0;
         m_prio    = 0;
         m_wrapped = '0;
         m_buserr  = 0;
         m_addr    = '0;
         m_data    = '0;
         return;
      end
      if (!model_on) return;
      if (status_clear) begin
         m_wrapped = '0;
         m_buserr  = 0;
      end
      if (m_active) begin
         offs = edge_n - m_E;
         if (offs == 1) begin
            m_data = data_in[m_sel*DW +: DW];
            m_addr = {CW'(m_sel), OW'(m_wptr[m_sel])};
         end
         if (offs == m_W + 1 && m_abort) m_buserr = 1;
         if (offs == m_W + 2) begin
            if (!m_abort) begin
               if (m_wptr[m_sel] == (1 << OW) - 1) begin
                  m_wptr[m_sel]    = 0;
                  m_wrapped[m_sel] = 1'b1;
               end else begin
                  m_wptr[m_sel] = m_wptr[m_sel] + 1;
               end
            end
            m_prio   = (m_sel + 1) % N;
            m_active = 0;
            m_done_cnt++;
         end
      end else if (enable && start_sram != '0) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_prio + k) % N;
            if (start_sram[c]) begin
               m_sel = c;
               break;
            end
         end
         m_active = 1;
         m_E      = edge_n;
         if (ack_wait < 0 || ack_wait + 1 > TO) begin
            m_W     = TO;
            m_abort = 1;
         end else begin
            m_W     = ack_wait + 1;
            m_abort = 0;
         end
      end
   endtask

   task automatic compare_all();
      logic [N-1:0] eg, ed;
      logic         ew, eb;
      int           offs;
      eg = '0; ed = '0; ew = 1'b0; eb = 1'b0;
      if (m_active) begin
         offs = edge_n - m_E;
         eg   = N'(1) << m_sel;
         eb   = 1'b1;
         ew   = (offs >= 1 && offs <= m_W);
         if (offs == m_W + 1) ed = eg;
      end
      check("grant",           64'(grant),           64'(eg));
      check("sram_we",         64'(sram_we),         64'(ew));
      check("data_done",       64'(data_done),       64'(ed));
      check("busy",            64'(busy),            64'(eb));
      check("sram_addr",       64'(sram_addr),       64'(m_addr));
      check("sram_data",       64'(sram_data),       64'(m_data));
      check("channel_wrapped", 64'(channel_wrapped), 64'(m_wrapped));
      check("bus_error",       64'(bus_error),       64'(m_buserr));
   endtask

   // Model update on each edge, then ack drive and output compare 1 time unit later.
   initial begin
      forever begin
         @(posedge clk);
         edge_n++;
         model_edge();
         #1;
         sram_ack = m_active && !m_abort && (edge_n - m_E) == m_W;
         if (model_on) compare_all();
         if (sram_we) we_cnt++;
         if (grant != '0 && prev_grant == '0) begin
            for (int k = 0; k < N; k++) if (grant[k]) glog_ch.push_back(k);
            glog_edge.push_back(edge_n);
         end
         prev_grant = grant;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_grant(input string name);
      int t;
      t = 0;
      while (grant == '0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      check(name, 64'(grant != '0), 64'(1));
   endtask

   task automatic wait_done(input string name, input int target, input int budget);
      int t;
      t = 0;
      while (m_done_cnt < target && t < budget) begin
         @(negedge clk);
         t++;
      end
      check(name, 64'(m_done_cnt >= target), 64'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int base;
      rst = 1'b1; enable = 1'b0; start_sram = '0; data_in = '0; status_clear = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_grant", 64'(grant), 64'(0));
      check("reset_busy",  64'(busy),  64'(0));
      check("reset_we",    64'(sram_we), 64'(0));
      rst = 1'b0;
      enable = 1'b1;

      // 1: single zero-wait write from channel 1
      $display("T1 single write channel 1");
      ack_wait = 0;
      @(negedge clk);
      start_sram = 4'b0010;
      data_in[1*DW +: DW] = 32'hA5A5_0001;
      @(negedge clk);
      check("t1_grant_c1", 64'(grant), 64'(4'b0010));
      check("t1_we_c1",    64'(sram_we), 64'(0));
      start_sram = '0;
      @(negedge clk);
      check("t1_we_c2",   64'(sram_we), 64'(1));
      check("t1_addr_c2", 64'(sram_addr), 64'(10'h100));
      check("t1_data_c2", 64'(sram_data), 64'(32'hA5A5_0001));
      @(negedge clk);
      check("t1_done_c3",  64'(data_done), 64'(4'b0010));
      check("t1_grant_c3", 64'(grant), 64'(4'b0010));
      @(negedge clk);
      check("t1_grant_c4", 64'(grant), 64'(0));
      check("t1_busy_c4",  64'(busy), 64'(0));

      // 2: four continuous requesters, round-robin order and spacing
      $display("T2 round robin all channels");
      reset_dut();
      glog_ch.delete();
      glog_edge.delete();
      for (int k = 0; k < N; k++) data_in[k*DW +: DW] = 32'hC0DE_0000 + 32'(k);
      start_sram = 4'b1111;
      begin
         int t;
         t = 0;
         while (glog_ch.size() < 5 && t < 100) begin
            @(negedge clk);
            t++;
         end
      end
      start_sram = '0;
      check("t2_grant_count", 64'(glog_ch.size() >= 5), 64'(1));
      if (glog_ch.size() >= 5) begin
         check("t2_order0", 64'(glog_ch[0]), 64'(0));
         check("t2_order1", 64'(glog_ch[1]), 64'(1));
         check("t2_order2", 64'(glog_ch[2]), 64'(2));
         check("t2_order3", 64'(glog_ch[3]), 64'(3));
         check("t2_order4", 64'(glog_ch[4]), 64'(0));
         for (int i = 0; i < 4; i++) check("t2_spacing", 64'(glog_edge[i+1] - glog_edge[i]), 64'(4));
      end
      wait_done("t2_done", m_done_cnt + 1, 20);
      repeat (4) @(negedge clk);

      // 3: channel 0 wraps its 256-word region
      $display("T3 channel 0 pointer wrap");
      reset_dut();
      base = m_done_cnt;
      data_in[0 +: DW] = 32'h0000_BEEF;
      start_sram = 4'b0001;
      wait_done("t3_256_done", base + 256, 256*4 + 40);
      check("t3_wrapped_set", 64'(channel_wrapped), 64'(4'b0001));
      check("t3_last_addr",   64'(sram_addr), 64'(10'h0FF));
      @(negedge clk);
      start_sram = '0;
      @(negedge clk);
      check("t3_257_we",   64'(sram_we), 64'(1));
      check("t3_257_addr", 64'(sram_addr), 64'(10'h000));
      wait_done("t3_257_done", base + 257, 20);
      status_clear = 1'b1;
      @(negedge clk);
      status_clear = 1'b0;
      check("t3_wrapped_clr", 64'(channel_wrapped), 64'(0));

      // 4: ack withheld on channel 2 -> timeout, then same address reused
      $display("T4 timeout on channel 2");
      ack_wait = -1;
      we_cnt = 0;
      start_sram = 4'b0100;
      data_in[2*DW +: DW] = 32'h1234_5678;
      wait_grant("t4_grant");
      start_sram = '0;
      wait_done("t4_done", m_done_cnt + 1, 300);
      check("t4_bus_error", 64'(bus_error), 64'(1));
      check("t4_we_cycles", 64'(we_cnt), 64'(255));
      check("t4_addr",      64'(sram_addr), 64'(10'h200));
      ack_wait = 0;
      start_sram = 4'b0100;
      wait_grant("t4_retry_grant");
      start_sram = '0;
      wait_done("t4_retry_done", m_done_cnt + 1, 20);
      check("t4_retry_addr", 64'(sram_addr), 64'(10'h200));
      status_clear = 1'b1;
      @(negedge clk);
      status_clear = 1'b0;
      check("t4_bus_error_clr", 64'(bus_error), 64'(0));

      // 5: request dropped during GRANT; enable dropped mid-transaction
      $display("T5 dropped request and enable");
      ack_wait = 3;
      data_in[2*DW +: DW] = 32'h5555_AAAA;
      start_sram = 4'b0100;
      wait_grant("t5_grant");
      start_sram = '0;
      wait_done("t5_done", m_done_cnt + 1, 20);
      check("t5_data", 64'(sram_data), 64'(32'h5555_AAAA));
      check("t5_addr", 64'(sram_addr), 64'(10'h201));
      ack_wait = 0;
      data_in[3*DW +: DW] = 32'h3333_0003;
      start_sram = 4'b1000;
      wait_grant("t5_ch3_grant");
      enable = 1'b0;
      wait_done("t5_ch3_done", m_done_cnt + 1, 20);
      repeat (20) @(negedge clk);
      check("t5_disabled_grant", 64'(grant), 64'(0));
      check("t5_disabled_busy",  64'(busy), 64'(0));
      start_sram = '0;
      enable = 1'b1;

      // 6: reset during WRITE abandons the write and clears pointers
      $display("T6 reset during write");
      ack_wait = -1;
      start_sram = 4'b0100;
      wait_grant("t6_grant");
      start_sram = '0;
      repeat (5) @(negedge clk);
      check("t6_in_write", 64'(sram_we), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      check("t6_we",    64'(sram_we), 64'(0));
      check("t6_grant", 64'(grant), 64'(0));
      check("t6_done",  64'(data_done), 64'(0));
      rst = 1'b0;
      ack_wait = 0;
      start_sram = 4'b0100;
      wait_grant("t6_after_grant");
      start_sram = '0;
      wait_done("t6_after_done", m_done_cnt + 1, 20);
      check("t6_ptr_zero_addr", 64'(sram_addr), 64'(10'h200));
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
